// File: rtl/exc_if.sv
// MEM-stage exception/interrupt bundle between the pipeline and the exception controller.
interface exc_if;
  logic        mem_valid_i;
  logic [5:0]  mem_exc_i;
  logic [31:0] mem_pc_i;
  logic        mem_is_slot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        exception_en_o;
  logic        is_exception_o;
  logic        is_interrupt_o;
  logic [4:0]  excepttype_o;
  logic [31:0] pc_next_o;
  logic        is_slot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [5:0]  stall_o;

  modport master (
    output mem_valid_i, mem_exc_i, mem_pc_i, mem_is_slot_i,
           status_i, cause_i, epc_i, stallreq_id_i, stallreq_ex_i,
    input  exception_en_o, is_exception_o, is_interrupt_o, excepttype_o,
           pc_next_o, is_slot_o, flush_o, new_pc_o, stall_o
  );

  modport slave (
    input  mem_valid_i, mem_exc_i, mem_pc_i, mem_is_slot_i,
           status_i, cause_i, epc_i, stallreq_id_i, stallreq_ex_i,
    output exception_en_o, is_exception_o, is_interrupt_o, excepttype_o,
           pc_next_o, is_slot_o, flush_o, new_pc_o, stall_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: prioritises MEM-stage events, strobes CP0, redirects and flushes the pipe.
//   state | meaning
//   IDLE  | watching MEM stage for an interrupt or exception
//   FLUSH | redirect in progress, flush_o held, new events ignored
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  exc_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        exc_en_q, is_exc_q, is_int_q, flush_q, is_slot_q;
  logic [4:0]  etype_q, etype_d;
  logic [31:0] pc_next_q, new_pc_q, new_pc_d;
  logic [5:0]  stall_q, stall_d;
  logic        ipend, detect, flush_d;
  logic        unused_bits;

  assign ipend = bus.status_i[0] & ~bus.status_i[1] &
                 (|(bus.cause_i[15:8] & bus.status_i[15:8]));

  // Interrupts win; ERET is only chosen when nothing else is flagged.
  always_comb begin
    etype_d  = 5'h1E;
    new_pc_d = EXC_VECTOR;
    if (ipend)                 etype_d = 5'h00;
    else if (bus.mem_exc_i[0]) etype_d = 5'h04;
    else if (bus.mem_exc_i[1]) etype_d = 5'h0A;
    else if (bus.mem_exc_i[2]) etype_d = 5'h0C;
    else if (bus.mem_exc_i[3]) etype_d = 5'h08;
    else if (bus.mem_exc_i[4]) etype_d = 5'h09;
    else                       new_pc_d = bus.epc_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    detect  = 1'b0;
    case (state_q)
      IDLE: begin
        detect = bus.mem_valid_i & (ipend | (|bus.mem_exc_i));
        if (detect) begin
          state_d = FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is aligned with the registered flush so flush always overrides it.
  always_comb begin
    flush_d = (state_d == FLUSH);
    stall_d = 6'b000000;
    if (!flush_d) begin
      if (bus.stallreq_ex_i)      stall_d = 6'b001111;
      else if (bus.stallreq_id_i) stall_d = 6'b000111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      exc_en_q  <= 1'b0;
      is_exc_q  <= 1'b0;
      is_int_q  <= 1'b0;
      flush_q   <= 1'b0;
      is_slot_q <= 1'b0;
      etype_q   <= 5'h00;
      pc_next_q <= 32'h0;
      new_pc_q  <= 32'h0;
      stall_q   <= 6'b000000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      exc_en_q <= detect;
      is_int_q <= detect & ipend;
      is_exc_q <= detect & ~ipend;
      flush_q  <= flush_d;
      stall_q  <= stall_d;
      if (detect) begin
        etype_q   <= etype_d;
        new_pc_q  <= new_pc_d;
        is_slot_q <= bus.mem_is_slot_i;
        pc_next_q <= bus.mem_is_slot_i ? (bus.mem_pc_i - 32'd4) : bus.mem_pc_i;
      end
    end
  end

  assign bus.exception_en_o = exc_en_q;
  assign bus.is_exception_o = is_exc_q;
  assign bus.is_interrupt_o = is_int_q;
  assign bus.excepttype_o   = etype_q;
  assign bus.pc_next_o      = pc_next_q;
  assign bus.is_slot_o      = is_slot_q;
  assign bus.flush_o        = flush_q;
  assign bus.new_pc_o       = new_pc_q;
  assign bus.stall_o        = stall_q;

  assign unused_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:16], bus.cause_i[7:0]};

endmodule
